sme_host: RTL and testbench

Host-side driver for the string-matching engine (SME). Software-style loaders fill a string buffer and a pattern buffer; on `start` the block serialises them onto the engine's `chardata`/`isstring`/`ispattern` stream. It then waits for the engine's one-cycle `valid`, captures `match`/`match_index` and presents the result with a `done` pulse. It sits between the test/host logic and the SME, and owns every protocol rule on the engine's input side.

---
 rtl/sme_pkg.sv | 22 ++
 rtl/sme_char_buf.sv | 53 +++++
 rtl/sme_host.sv | 249 ++++++++++++++++++++++++
 tb/tb_sme_host.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// sme_pkg: shared types and constants for the string-matching engine host.
//   char_t        - one 8-bit character on the engine stream
//   CH_*          - characters with special meaning to the engine (passed through untouched)
//   host_state_e  - host transaction FSM states
package sme_pkg;

    typedef logic [7:0] char_t;

    localparam char_t CH_START = 8'h5E;  // '^' anchor at string start
    localparam char_t CH_END   = 8'h24;  // '$' anchor at string end
    localparam char_t CH_ANY   = 8'h2E;  // '.' wildcard
    localparam char_t CH_SPACE = 8'h20;  // word separator

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_STR = 3'd1,
        ST_SEND_PAT = 3'd2,
        ST_WAIT     = 3'd3,
        ST_DONE     = 3'd4
    } host_state_e;

endpackage

// File: rtl/sme_char_buf.sv
// sme_char_buf: append-only character buffer with clear and indexed read.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset (empties the buffer)
//   clr             - empty the buffer (takes priority over wr_en)
//   wr_en, wr_data  - append one character; dropped when full
//   rd_idx, rd_data - combinational read of one stored character
//   len, full       - current fill level and full flag
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       wr_en,
    input  char_t                      wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output char_t                      rd_data,
    output logic [$clog2(DEPTH):0]     len,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    char_t mem [DEPTH];

    assign full    = (len == DEPTH_L);
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len <= '0;
        end else if (clr) begin
            len <= '0;
        end else if (wr_en && !full) begin
            // NOTE: sequential state uses non-blocking (<=) so every register samples
            // pre-edge values; blocking here would create order-dependent races.
            len <= len + LW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; len alone defines which entries are
    // valid, and leaving the array reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en && !full && !clr) begin
            mem[len[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sme_host.sv
// sme_host: host-side driver for the string-matching engine.
// Loaders fill a string and a pattern buffer; on start the block streams the string
// (isstring) then the pattern (ispattern) to the engine, waits for valid, and
// presents match/match_index on res_* with a one-cycle done strobe.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   wr_en, wr_sel, wr_data, clr - buffer loading (ignored while busy)
//   start, busy, done           - transaction control/status
//   res_match, res_index        - captured engine result
//   ovf                         - sticky: a write hit a full buffer (cleared by clr)
//   err                         - watchdog timeout (sticky until next accepted start)
//   chardata, isstring, ispattern - registered stream to the engine
//   valid, match, match_index   - result from the engine
// Configuration: define SME_HOST_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYC cycles); otherwise WAIT is held until valid and err is tied 0.
module sme_host
    import sme_pkg::*;
#(
    parameter int STR_MAX     = 32,
    parameter int PAT_MAX     = 8,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       ovf,
    output logic       err,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index
);

    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int SLW = SAW + 1;
    localparam int PLW = PAW + 1;

    host_state_e    state, state_nxt;
    logic [SLW-1:0] str_idx, str_idx_nxt, str_len;
    logic [PLW-1:0] pat_idx, pat_idx_nxt, pat_len;
    char_t          str_rd, pat_rd, ch_nxt;
    logic           isstr_nxt, ispat_nxt;
    logic           str_full, pat_full;
    logic           start_ok, to_str, capture, timeout;
    logic           str_dirty;

    // Loader side is frozen while a transaction is in flight.
    logic clr_acc, wr_acc, str_wr, pat_wr;
    assign clr_acc = clr && !busy;
    assign wr_acc  = wr_en && !busy && !clr;
    assign str_wr  = wr_acc && !wr_sel;
    assign pat_wr  = wr_acc && wr_sel;

    assign busy = (state == ST_SEND_STR) || (state == ST_SEND_PAT) || (state == ST_WAIT);
    assign done = (state == ST_DONE);

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_acc),
        .wr_en   (str_wr),
        .wr_data (wr_data),
        .rd_idx  (str_idx[SAW-1:0]),
        .rd_data (str_rd),
        .len     (str_len),
        .full    (str_full)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_acc),
        .wr_en   (pat_wr),
        .wr_data (wr_data),
        .rd_idx  (pat_idx[PAW-1:0]),
        .rd_data (pat_rd),
        .len     (pat_len),
        .full    (pat_full)
    );

    // The comb block computes the values the stream registers will show next
    // cycle, so the character for index k is fetched while index k-1 is on the bus.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt   = state;
        str_idx_nxt = str_idx;
        pat_idx_nxt = pat_idx;
        ch_nxt      = '0;
        isstr_nxt   = 1'b0;
        ispat_nxt   = 1'b0;
        start_ok    = 1'b0;
        to_str      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && (pat_len != '0)) begin
                    start_ok = 1'b1;
                    if (str_dirty && (str_len != '0)) begin
                        to_str      = 1'b1;
                        state_nxt   = ST_SEND_STR;
                        ch_nxt      = str_rd;
                        isstr_nxt   = 1'b1;
                        str_idx_nxt = SLW'(1);
                    end else begin
                        // Engine still holds the last string; send the pattern only.
                        state_nxt   = ST_SEND_PAT;
                        ch_nxt      = pat_rd;
                        ispat_nxt   = 1'b1;
                        pat_idx_nxt = PLW'(1);
                    end
                end
            end
            ST_SEND_STR: begin
                if (str_idx == str_len) begin
                    state_nxt   = ST_SEND_PAT;
                    str_idx_nxt = '0;
                    ch_nxt      = pat_rd;
                    ispat_nxt   = 1'b1;
                    pat_idx_nxt = PLW'(1);
                end else begin
                    ch_nxt      = str_rd;
                    isstr_nxt   = 1'b1;
                    str_idx_nxt = str_idx + SLW'(1);
                end
            end
            ST_SEND_PAT: begin
                if (pat_idx == pat_len) begin
                    state_nxt   = ST_WAIT;
                    pat_idx_nxt = '0;
                end else begin
                    ch_nxt      = pat_rd;
                    ispat_nxt   = 1'b1;
                    pat_idx_nxt = pat_idx + PLW'(1);
                end
            end
            ST_WAIT: begin
                if (valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (timeout) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            str_idx   <= '0;
            pat_idx   <= '0;
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
        end else begin
            state     <= state_nxt;
            str_idx   <= str_idx_nxt;
            pat_idx   <= pat_idx_nxt;
            chardata  <= ch_nxt;
            isstring  <= isstr_nxt;
            ispattern <= ispat_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (clr_acc) begin
            ovf <= 1'b0;
        end else if ((str_wr && str_full) || (pat_wr && pat_full)) begin
            ovf <= 1'b1;
        end
    end

    // str_dirty: the engine's copy of the string may be stale and must be resent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_dirty <= 1'b1;
        end else if (clr_acc || str_wr || timeout) begin
            str_dirty <= 1'b1;
        end else if (to_str) begin
            str_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_match <= 1'b0;
            res_index <= '0;
        end else if (capture) begin
            res_match <= match;
            res_index <= match_index;
        end else if (timeout) begin
            res_match <= 1'b0;
            res_index <= '0;
        end
    end

`ifdef SME_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Fires on the last of TIMEOUT_CYC WAIT cycles; a same-cycle valid wins.
    assign timeout = (state == ST_WAIT) && !valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;

    // No watchdog in this build; TIMEOUT_CYC keeps the parameter list identical
    // to timeout-enabled builds.
    if (TIMEOUT_CYC < 0) begin : g_timeout_unused
    end
`endif

endmodule

// File: tb/tb_sme_host.sv
// tb_sme_host: directed self-checking bench for sme_host.
// A simple engine model collects the isstring/ispattern stream, then returns
// valid with a chosen match/match_index. Inputs change and outputs are sampled
// on the falling clock edge. Define SME_HOST_TIMEOUT_EN to also run the watchdog case.
module tb_sme_host;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel, clr, start;
    logic [7:0] wr_data;
    logic       busy, done, res_match, ovf, err;
    logic [4:0] res_index;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid, match;
    logic [4:0] match_index;

    int checks = 0;
    int errors = 0;
    byte got_s[$];
    byte got_p[$];

    always #5 clk = ~clk;

    sme_host #(
        .STR_MAX(32),
        .PAT_MAX(8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .clr         (clr),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .res_match   (res_match),
        .res_index   (res_index),
        .ovf         (ovf),
        .err         (err),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_resm"}, res_match, 0);
        check({tag, "_resi"}, res_index, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_chr"}, chardata, 0);
        check({tag, "_isstr"}, isstring, 0);
        check({tag, "_ispat"}, ispattern, 0);
    endtask

    task automatic write_buf(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_data = s[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Pulse start, record the stream until it goes quiet, compare with the
    // expected string/pattern. With inject set, a start, a pattern write and a
    // stray valid are driven during the first streamed cycle; all must be ignored.
    task automatic run_stream(input string exp_s, input string exp_p, input bit inject);
        int n;
        got_s.delete();
        got_p.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((isstring || ispattern) && n < 100) begin
            check("excl", {31'd0, isstring & ispattern}, 0);
            if (isstring)  got_s.push_back(byte'(chardata));
            if (ispattern) got_p.push_back(byte'(chardata));
            if (inject && n == 0) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_data = "z";
                valid = 1'b1; match = 1'b1; match_index = 5'd31;
            end else begin
                start = 1'b0; wr_en = 1'b0;
                valid = 1'b0; match = 1'b0; match_index = 5'd0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; wr_en = 1'b0;
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        check("str_len", got_s.size(), exp_s.len());
        for (int i = 0; i < exp_s.len(); i++)
            check("str_chr", (i < got_s.size()) ? got_s[i] : 8'h00, exp_s[i]);
        check("pat_len", got_p.size(), exp_p.len());
        for (int i = 0; i < exp_p.len(); i++)
            check("pat_chr", (i < got_p.size()) ? got_p[i] : 8'h00, exp_p[i]);
        check("wait_busy", busy, 1);
        check("wait_chr", chardata, 0);
        check("wait_done", done, 0);
    endtask

    // Engine model answer, given while the host sits in WAIT.
    task automatic respond(input logic m, input logic [4:0] idx);
        repeat (2) @(negedge clk);
        check("wait_hold", busy, 1);
        valid = 1'b1; match = m; match_index = idx;
        @(negedge clk);
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        check("done", done, 1);
        check("res_match", res_match, m);
        check("res_index", res_index, idx);
        check("done_busy", busy, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("res_hold", res_index, idx);
        @(negedge clk);
        check("no_requeue", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'h00; clr = 1'b0; start = 1'b0;
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // start with an empty pattern buffer is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nopat_busy", busy, 0);
        check("nopat_isstr", isstring, 0);
        @(negedge clk);
        check("nopat_busy2", busy, 0);

        // full run: string then pattern
        write_buf(1'b0, "abc de");
        write_buf(1'b1, "de");
        run_stream("abc de", "de", 1'b0);
        respond(1'b1, 5'd4);
        check("err_clean", err, 0);

        // string already in engine: pattern only, busy-time writes/start/valid dropped
        run_stream("", "de", 1'b1);
        respond(1'b0, 5'd3);
        run_stream("", "de", 1'b0);
        respond(1'b1, 5'd4);

        // anchored pattern after clear
        do_clr();
        write_buf(1'b1, "^ab");
        run_stream("", "^ab", 1'b0);
        respond(1'b1, 5'd0);

        // string overflow: 33rd character dropped, ovf sticky until clr
        do_clr();
        write_buf(1'b1, ".$");
        write_buf(1'b0, "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345");
        check("ovf_at_full", ovf, 0);
        write_buf(1'b0, "6");
        check("ovf_set", ovf, 1);
        run_stream("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", ".$", 1'b0);
        respond(1'b1, 5'd31);
        check("ovf_sticky", ovf, 1);
        do_clr();
        check("ovf_clr", ovf, 0);

        // reset during SEND_STR
        write_buf(1'b0, "hello");
        write_buf(1'b1, "lo");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_isstr", isstring, 1);
        check("mid_chr", chardata, "h");
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        write_buf(1'b0, "hello");
        write_buf(1'b1, "lo");
        run_stream("hello", "lo", 1'b0);
        respond(1'b1, 5'd3);

`ifdef SME_HOST_TIMEOUT_EN
        begin
            int n;
            do_clr();
            write_buf(1'b1, "q");
            run_stream("", "q", 1'b0);
            n = 0;
            while (!done && n < 64) begin
                @(negedge clk);
                n++;
            end
            check("wd_cycles", n, 16);
            check("wd_err", err, 1);
            check("wd_resm", res_match, 0);
            check("wd_resi", res_index, 0);
            @(negedge clk);
            check("wd_err_sticky", err, 1);
            run_stream("", "q", 1'b0);
            check("wd_err_clr", err, 0);
            respond(1'b1, 5'd2);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
